// File: rtl/data_sram_resp.sv
// Data SRAM responder: word-addressed storage with byte enables, a post-reset
// self-clear sequence and a sticky record of the first illegal access.
module data_sram_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        err_valid,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  localparam logic [1:0] CAUSE_RANGE = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;
  localparam logic [1:0] CAUSE_INIT  = 2'b11;

  typedef enum logic {INIT, READY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          init_wr;

  logic [31:0]   off;
  logic          in_range;
  logic          misaligned;
  logic [AW-1:0] idx;
  logic          access;
  logic          acc_ok;
  logic          err_hit;
  logic [1:0]    err_code;

  logic [31:0]   mem [DEPTH];

  // Init sequencer: one word cleared per cycle, READY is terminal
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    init_wr   = 1'b0;
    case (state)
      INIT: begin
        init_wr = 1'b1;
        ptr_nxt = ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = INIT;
    endcase
  end

  assign off        = data_sram_addr - BASE_ADDR;
  assign in_range   = off < SPAN;
  assign misaligned = |data_sram_addr[1:0];
  assign idx        = off[AW+1:2];
  assign access     = (state == READY) && data_sram_en;
  assign acc_ok     = access && in_range;

  // Error classification; out-of-range outranks misalignment
  always_comb begin
    err_hit  = 1'b0;
    err_code = 2'b00;
    if (data_sram_en) begin
      if (state == INIT) begin
        err_hit  = 1'b1;
        err_code = CAUSE_INIT;
      end else if (!in_range) begin
        err_hit  = 1'b1;
        err_code = CAUSE_RANGE;
      end else if (misaligned) begin
        err_hit  = 1'b1;
        err_code = CAUSE_ALIGN;
      end
    end
  end

  // Storage array is cleared by the init sequence rather than by reset
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[ptr] <= INIT_VAL;
    end else if (acc_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= INIT;
      ptr             <= '0;
      init_done       <= 1'b0;
      data_sram_rdata <= '0;
      err_valid       <= 1'b0;
      err_cause       <= 2'b00;
      err_addr        <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      init_done <= (state_nxt == READY);
      // Read-first: the pre-write word is returned
      if (access) data_sram_rdata <= in_range ? mem[idx] : '0;
      if (err_hit && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_cause <= err_code;
        err_addr  <= data_sram_addr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_cause <= 2'b00;
        err_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed vector table, init/reset sequences and a
// randomized run against an array-based reference model.
module tb_data_sram_resp;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] IV    = 32'h5A5A_A5C3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        clr = 1'b0;
  logic [31:0] rdata;
  logic        init_done;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  data_sram_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .INIT_VAL(IV)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata),
    .init_done(init_done), .err_valid(err_valid), .err_cause(err_cause),
    .err_addr(err_addr), .err_clr(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] rdata;
    logic        ev;
    logic [1:0]  cause;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs [18];

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_ev;
  logic [1:0]  m_cause;
  logic [31:0] m_eaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic c);
    en = e; we = w; addr = a; wdata = d; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after reset release until init_done; bounded
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Model one accepted cycle in READY, from the access rules directly
  task automatic model_step(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d, input logic c);
    logic [31:0] o;
    logic        hit;
    logic [1:0]  code;
    int unsigned wi;
    o = a - BASE;
    hit = 1'b0;
    code = 2'b00;
    if (e) begin
      if (o >= DEPTH * 4) begin
        m_rdata = 32'h0;
        hit = 1'b1;
        code = 2'b01;
      end else begin
        wi = o / 4;
        m_rdata = m_mem[wi];
        for (int b = 0; b < 4; b++)
          if (w[b]) m_mem[wi][8*b +: 8] = d[8*b +: 8];
        if (a % 4 != 0) begin
          hit = 1'b1;
          code = 2'b10;
        end
      end
    end
    if (hit && (!m_ev || c)) begin
      m_ev = 1'b1; m_cause = code; m_eaddr = a;
    end else if (c) begin
      m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0;
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra;

    vecs[0]  = '{1, 4'hF, 32'h08, 32'hDEADBEEF, 0, IV,           0, 2'b00, 32'h0};
    vecs[1]  = '{1, 4'h0, 32'h08, 32'h0,        0, 32'hDEADBEEF, 0, 2'b00, 32'h0};
    vecs[2]  = '{1, 4'hF, 32'h08, 32'h01020304, 0, 32'hDEADBEEF, 0, 2'b00, 32'h0};
    vecs[3]  = '{1, 4'h0, 32'h08, 32'h0,        0, 32'h01020304, 0, 2'b00, 32'h0};
    vecs[4]  = '{1, 4'hF, 32'h04, 32'h11223344, 0, IV,           0, 2'b00, 32'h0};
    vecs[5]  = '{1, 4'h5, 32'h04, 32'hAABBCCDD, 0, 32'h11223344, 0, 2'b00, 32'h0};
    vecs[6]  = '{1, 4'h0, 32'h04, 32'h0,        0, 32'h11BB33DD, 0, 2'b00, 32'h0};
    vecs[7]  = '{1, 4'h0, 32'h40, 32'h0,        0, 32'h0,        1, 2'b01, 32'h40};
    vecs[8]  = '{1, 4'h0, 32'h05, 32'h0,        0, 32'h11BB33DD, 1, 2'b01, 32'h40};
    vecs[9]  = '{1, 4'h0, 32'h05, 32'h0,        1, 32'h11BB33DD, 1, 2'b10, 32'h05};
    vecs[10] = '{0, 4'h0, 32'h00, 32'h0,        1, 32'h11BB33DD, 0, 2'b00, 32'h0};
    vecs[11] = '{1, 4'hF, 32'h07, 32'h0,        0, 32'h11BB33DD, 1, 2'b10, 32'h07};
    vecs[12] = '{1, 4'h0, 32'h04, 32'h0,        1, 32'h0,        0, 2'b00, 32'h0};
    vecs[13] = '{1, 4'h3, 32'h44, 32'hFFFFFFFF, 0, 32'h0,        1, 2'b01, 32'h44};
    vecs[14] = '{0, 4'hF, 32'h08, 32'h0,        0, 32'h0,        1, 2'b01, 32'h44};
    vecs[15] = '{1, 4'h0, 32'h08, 32'h0,        1, 32'h01020304, 0, 2'b00, 32'h0};
    vecs[16] = '{1, 4'hF, 32'hFFFFFFFC, 32'h0,  0, 32'h0,        1, 2'b01, 32'hFFFFFFFC};
    vecs[17] = '{1, 4'h0, 32'h3C, 32'h0,        1, IV,           0, 2'b00, 32'h0};

    // Reset values
    tick(); tick();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_init_done", 32'(init_done), 32'h0);
    chk("reset_err_valid", 32'(err_valid), 32'h0);
    chk("reset_err_cause", 32'(err_cause), 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);

    // Plain reset release: init takes exactly DEPTH cycles
    resetn = 1'b1;
    wait_init(n);
    chk("init_cycles", 32'(n), 32'(DEPTH));
    drive(1, 4'h0, 32'h08, 32'h0, 0);
    tick();
    chk("init_read_8", rdata, IV);
    chk("init_err_valid", 32'(err_valid), 32'h0);

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
      tick();
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("vec%0d_ev", i), 32'(err_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_cause", i), 32'(err_cause), 32'(vecs[i].cause));
      chk($sformatf("vec%0d_eaddr", i), err_addr, vecs[i].eaddr);
    end

    // Access on the third INIT cycle is rejected and flagged
    drive(0, 4'h0, 32'h0, 32'h0, 0);
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin
      if (n == 2) drive(1, 4'hF, 32'h0, 32'hFFFFFFFF, 0);
      else drive(0, 4'h0, 32'h0, 32'h0, 0);
      tick();
      n++;
    end
    chk("initacc_cycles", 32'(n), 32'(DEPTH));
    chk("initacc_ev", 32'(err_valid), 32'h1);
    chk("initacc_cause", 32'(err_cause), 32'h3);
    chk("initacc_eaddr", err_addr, 32'h0);
    chk("initacc_rdata", rdata, 32'h0);
    drive(1, 4'h0, 32'h0, 32'h0, 1);
    tick();
    chk("initacc_word0", rdata, IV);
    chk("initacc_cleared", 32'(err_valid), 32'h0);

    // Randomized run against the model (memory freshly cleared)
    for (int i = 0; i < DEPTH; i++) m_mem[i] = IV;
    m_rdata = IV; m_ev = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = 32'h40 + 32'($urandom_range(0, 15));
        default: ra = 32'($urandom_range(0, 63));
      endcase
      drive($urandom_range(0, 9) != 0, 4'($urandom), ra, $urandom,
            $urandom_range(0, 9) == 0);
      model_step(en, we, addr, wdata, clr);
      tick();
      chk("rnd_rdata", rdata, m_rdata);
      chk("rnd_ev", 32'(err_valid), 32'(m_ev));
      chk("rnd_cause", 32'(err_cause), 32'(m_cause));
      chk("rnd_eaddr", err_addr, m_eaddr);
    end

    // Mid-operation reset restarts the clear
    drive(1, 4'hF, 32'h0, 32'h12345678, 0);
    tick();
    drive(1, 4'h0, 32'h0, 32'h0, 0);
    tick();
    chk("midrst_pre_rdata", rdata, 32'h12345678);
    drive(0, 4'h0, 32'h0, 32'h0, 0);
    resetn = 1'b0;
    #1;
    chk("midrst_init_done", 32'(init_done), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_err_valid", 32'(err_valid), 32'h0);
    tick();
    resetn = 1'b1;
    wait_init(n);
    chk("midrst_cycles", 32'(n), 32'(DEPTH));
    drive(1, 4'h0, 32'h0, 32'h0, 0);
    tick();
    chk("midrst_word0", rdata, IV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the data SRAM interface driven by the execute stage: accepts the en/we/addr/wdata request and returns read data one cycle later.
- Holds a parameterised word-addressed storage array with per-byte write enables.
- After reset it runs a self-clear sequence before accepting accesses.
- Flags illegal accesses (out of range, misaligned, issued during init) in a sticky error record for debug and testbench checking.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH*4 aligned.
- INIT_VAL, 32'h0000_0000: value written into every word during the init sequence.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_en  in  1  access request this cycle.
- data_sram_we  in  4  byte write enables; bit i writes wdata[8i+7:8i]; 4'h0 means read.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  registered read data.
- init_done  out  1  1 once the init sequence has completed.
- err_valid  out  1  sticky error record present.
- err_cause  out  2  01 out-of-range, 10 misaligned, 11 access during init.
- err_addr  out  32  data_sram_addr of the captured error.
- err_clr  in  1  clears the error record (synchronous).

Behaviour:
- Reset, asynchronous on resetn low:
  - FSM enters INIT with init pointer = 0.
  - data_sram_rdata = 0, init_done = 0, err_valid = 0, err_cause = 0, err_addr = 0.
  - Array contents are not reset directly; the INIT state clears them.
- FSM has two states, INIT and READY.
- INIT:
  - One word per cycle: mem[ptr] <= INIT_VAL, ptr++.
  - When ptr == DEPTH-1 is written, next state is READY. INIT therefore lasts exactly DEPTH cycles after resetn rises.
  - init_done rises on the first READY cycle.
- READY: terminal state; it is left only through reset.
- resetn asserted mid-INIT or in READY: the FSM immediately returns to INIT with ptr = 0 and the full clear restarts.
- Decode:
  - off = addr - BASE_ADDR (32-bit wrap).
  - in_range = off < DEPTH*4.
  - idx = off[log2(DEPTH)+1:2].
  - misaligned = addr[1:0] != 0.
- Access in READY with en = 1 and in_range:
  - Read-first: data_sram_rdata <= mem[idx] as it was before this cycle's write, regardless of we.
  - For each set we bit, the corresponding byte of mem[idx] is updated at the same edge.
  - A read in cycle N returns data in cycle N+1. A write in cycle N is visible to a read issued in cycle N+1.
- Misaligned address (en = 1, in_range): low two address bits are ignored, so the access proceeds on word idx. Error cause 10 is raised.
- Out-of-range address (en = 1, !in_range): no array write; data_sram_rdata <= 0; error cause 01. Out-of-range takes priority over misaligned.
- en = 1 during INIT: access ignored (no write, rdata unchanged); error cause 11.
- en = 0: no array access; data_sram_rdata holds its value.
- Error record:
  - Captures the first error: err_valid <= 1, with err_cause and err_addr loaded.
  - Later errors do not overwrite the record while err_valid = 1.
  - err_clr = 1 clears err_valid, err_cause and err_addr to 0. If a new error occurs in the same cycle as err_clr, the new error is captured instead.
- we != 0 with en = 0 has no effect. The execute stage holds en = 1 constantly, so every cycle in READY is an access.
- No backpressure: the responder accepts an access every cycle in READY.

Test Plan:
- Reset release, DEPTH = 16: init_done = 0 for exactly 16 cycles, then rises. A read of addr 0x8 returns INIT_VAL the following cycle; err_valid = 0.
- Full-word write then read:
  - Write 0x8 <= 0xDEADBEEF with we = 4'hF. A read of 0x8 in the next cycle returns 0xDEADBEEF.
  - A write and read of the same address in the same cycle returns the old value.
- Byte enables: word at 0x4 = 0x11223344; write we = 4'b0101 with wdata 0xAABBCCDD. Readback is 0x11BB33DD.
- Errors:
  - Access to addr 0x40 (DEPTH = 16) gives rdata = 0, err_valid = 1, err_cause = 01, err_addr = 0x40.
  - A subsequent misaligned access to 0x5 leaves the record unchanged.
  - err_clr together with the 0x5 access captures err_cause = 10, err_addr = 0x5.
- Access during init: en = 1 with we = 4'hF to 0x0 on cycle 3 of INIT gives err_cause = 11. After init_done, word 0 reads INIT_VAL.
- Mid-operation reset: write 0x0 <= 0x12345678, pulse resetn low for 1 cycle. init_done drops asynchronously, rdata = 0, 16 INIT cycles follow, and word 0 reads INIT_VAL.
